// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Two-requester arbiter/sequencer for a single-port word RAM. Serialises
//   read/write requests from two masters onto one RAM port, produces a
//   single-cycle write strobe, captures read data per requester and returns a
//   one-cycle ack. Every transaction walks IDLE -> SETUP -> STROBE -> RESP.
//
// Parameters
//   ADDR_W : RAM address width (DEPTH = 2**ADDR_W words)
//   DATA_W : RAM word width
//
// Ports
//   clk, clear_n          : clock (posedge), asynchronous active-low reset
//   req0/1, rw0/1         : request (held until ack) and direction (1 = write)
//   addr0/1, wdata0/1     : request address and write data, sampled in IDLE
//   gnt0/1                : requester owns the RAM port (SETUP..RESP)
//   ack0/1                : one-cycle completion pulse
//   rdata0/1              : registered read data, updated only by own reads
//   ram_addr, ram_wdata   : RAM address / write data
//   ram_en                : RAM select, high SETUP..RESP
//   ram_we                : RAM write strobe, high for the STROBE cycle of a write
//   ram_rdata             : RAM read data (combinational from the RAM)
//
// Configuration
//   ARB_ROUND_ROBIN_EN : when defined, ties alternate between requesters;
//                        otherwise requester 0 always wins a tie.

module ram_port_arbiter #(
  parameter int ADDR_W = 1,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              rw0,
  input  logic              rw1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_en,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state;
  logic   owner;   // requester currently served (0/1)
  logic   is_wr;   // latched direction of the current transaction
  logic   pick;    // arbitration winner in IDLE

`ifdef ARB_ROUND_ROBIN_EN
  // Requester that wins the next tie; always the one not granted last.
  logic   prio;

  always_comb begin
    pick = 1'b0;
    if (req0 && req1) pick = prio;
    else              pick = ~req0;
  end
`else
  always_comb begin
    pick = 1'b0;
    if (!req0) pick = 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state     <= IDLE;
      owner     <= 1'b0;
      is_wr     <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      prio      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner     <= pick;
            is_wr     <= pick ? rw1 : rw0;
            ram_addr  <= pick ? addr1 : addr0;
            ram_wdata <= pick ? wdata1 : wdata0;
            gnt0      <= ~pick;
            gnt1      <= pick;
            ram_en    <= 1'b1;
            state     <= SETUP;
`ifdef ARB_ROUND_ROBIN_EN
            prio      <= ~pick;
`endif
          end
        end
        SETUP: begin
          // Registered strobe: raising it here makes it high during STROBE only.
          ram_we <= is_wr;
          state  <= STROBE;
        end
        STROBE: begin
          ram_we <= 1'b0;
          if (!is_wr) begin
            if (owner) rdata1 <= ram_rdata;
            else       rdata0 <= ram_rdata;
          end
          ack0  <= ~owner;
          ack1  <= owner;
          state <= RESP;
        end
        RESP: begin
          ack0   <= 1'b0;
          ack1   <= 1'b0;
          gnt0   <= 1'b0;
          gnt1   <= 1'b0;
          ram_en <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

  localparam int AW = 1;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          clear_n;
  logic          req0, req1, rw0, rw1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, ack0, ack1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] ram_addr;
  logic          ram_en, ram_we;
  logic [DW-1:0] ram_wdata, ram_rdata;

  int tests = 0;
  int fails = 0;

  // Reference model: word memory, per-requester last read value, last granted.
  logic [DW-1:0] mem_m [2**AW];
  logic [DW-1:0] rd_m  [2];
  bit            last_m;

  // Behavioural single-port RAM attached to the arbiter.
  logic [DW-1:0] ram_mem [2**AW];

  always #5 clk = ~clk;

  always @(posedge clk)
    if (ram_en && ram_we) ram_mem[ram_addr] <= ram_wdata;
  assign ram_rdata = ram_mem[ram_addr];

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .clear_n(clear_n),
    .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_addr(ram_addr), .ram_en(ram_en), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit tie_winner();
`ifdef ARB_ROUND_ROBIN_EN
    return ~last_m;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model_reset();
    rd_m[0] = '0;
    rd_m[1] = '0;
    last_m  = 1'b1;  // requester 0 has priority after reset
  endfunction

  // Runs one or two concurrent requests to completion, predicting the full
  // cycle-by-cycle behaviour from the arbitration and sequencing rules.
  task automatic run_xacts(input bit e0, input bit e1,
                           input bit ra, input bit rb,
                           input logic [AW-1:0] aa, input logic [AW-1:0] ab,
                           input logic [DW-1:0] da, input logic [DW-1:0] db,
                           input string nm);
    bit pend0, pend1, w, erw;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed, got_rd;
    logic [1:0] g, a;
    pend0 = e0; pend1 = e1;
    req0 = e0; rw0 = ra; addr0 = aa; wdata0 = da;
    req1 = e1; rw1 = rb; addr1 = ab; wdata1 = db;
    for (int unsigned k = 0; k < 2; k++) begin
      if (pend0 || pend1) begin
        w   = (pend0 && pend1) ? tie_winner() : pend1;
        erw = w ? rb : ra;
        ea  = w ? ab : aa;
        ed  = w ? db : da;
        tick();  // SETUP
        g = {gnt1, gnt0};
        tests++;
        if (g !== (w ? 2'b10 : 2'b01) || ram_en !== 1'b1 || ram_we !== 1'b0 || {ack1, ack0} !== 2'b00) begin
          fails++;
          $display("FAIL %s setup: gnt=%b en=%b we=%b ack=%b, need gnt=%b en=1 we=0 ack=00",
                   nm, g, ram_en, ram_we, {ack1, ack0}, w ? 2'b10 : 2'b01);
        end
        tick();  // STROBE
        tests++;
        if (ram_we !== erw || ram_addr !== ea || (erw && ram_wdata !== ed)) begin
          fails++;
          $display("FAIL %s strobe: we=%b addr=%h wdata=%h, need we=%b addr=%h wdata=%h",
                   nm, ram_we, ram_addr, ram_wdata, erw, ea, ed);
        end
        tick();  // RESP
        if (erw) mem_m[ea] = ed;
        else     rd_m[w]   = mem_m[ea];
        a      = {ack1, ack0};
        got_rd = w ? rdata1 : rdata0;
        tests++;
        if (a !== (w ? 2'b10 : 2'b01) || ram_we !== 1'b0 || got_rd !== rd_m[w]) begin
          fails++;
          $display("FAIL %s resp: ack=%b we=%b rdata%0d=%h, need ack=%b we=0 rdata=%h",
                   nm, a, ram_we, w, got_rd, w ? 2'b10 : 2'b01, rd_m[w]);
        end
        last_m = w;
        if (w) begin pend1 = 1'b0; req1 = 1'b0; end
        else   begin pend0 = 1'b0; req0 = 1'b0; end
        tick();  // IDLE
        tests++;
        if ({gnt1, gnt0, ram_en, ram_we, ack1, ack0} !== 6'b0) begin
          fails++;
          $display("FAIL %s idle: gnt=%b en=%b we=%b ack=%b, need all 0",
                   nm, {gnt1, gnt0}, ram_en, ram_we, {ack1, ack0});
        end
      end
    end
  endtask

  task automatic test_reset();
    clear_n = 1'b0;
    req0 = 0; req1 = 0; rw0 = 0; rw1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    model_reset();
    repeat (2) tick();
    tests++;
    if ({gnt1, gnt0, ack1, ack0, ram_en, ram_we} !== 6'b0 || ram_addr !== '0 ||
        ram_wdata !== '0 || rdata0 !== '0 || rdata1 !== '0) begin
      fails++;
      $display("FAIL reset_outputs: ctl=%b addr=%h wdata=%h rd0=%h rd1=%h, need all 0",
               {gnt1, gnt0, ack1, ack0, ram_en, ram_we}, ram_addr, ram_wdata, rdata0, rdata1);
    end
    @(negedge clk);
    clear_n = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      tests++;
      if ({gnt1, gnt0, ack1, ack0, ram_en, ram_we} !== 6'b0) begin
        fails++;
        $display("FAIL reset_idle: ctl=%b, need 000000", {gnt1, gnt0, ack1, ack0, ram_en, ram_we});
      end
    end
  endtask

  task automatic test_write();
    run_xacts(1, 0, 1, 0, 1'b0, 1'b0, 8'h03, 8'h00, "write0");
  endtask

  task automatic test_read_back();
    run_xacts(0, 1, 0, 1, 1'b0, 1'b1, 8'h00, 8'h09, "write1");
    run_xacts(0, 1, 0, 0, 1'b0, 1'b0, 8'h00, 8'h00, "read1_a0");
    run_xacts(0, 1, 0, 0, 1'b0, 1'b1, 8'h00, 8'h00, "read1_a1");
  endtask

  task automatic test_contention();
    bit w;
    logic [1:0] a;
    req0 = 1; req1 = 1; rw0 = 0; rw1 = 0; addr0 = 1'b0; addr1 = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      w = tie_winner();
      for (int unsigned c = 1; c <= 4; c++) begin
        tick();
        a = {ack1, ack0};
        if (c == 3) begin
          rd_m[w] = mem_m[w ? addr1 : addr0];
          tests++;
          if (a !== (w ? 2'b10 : 2'b01) || (w ? rdata1 : rdata0) !== rd_m[w]) begin
            fails++;
            $display("FAIL contention_ack k=%0d: ack=%b rd=%h, need ack=%b rd=%h",
                     k, a, w ? rdata1 : rdata0, w ? 2'b10 : 2'b01, rd_m[w]);
          end
          last_m = w;
          if (k == 3) begin req0 = 0; req1 = 0; end
        end else begin
          tests++;
          if (a !== 2'b00 || (gnt0 && gnt1)) begin
            fails++;
            $display("FAIL contention_quiet k=%0d c=%0d: ack=%b gnt=%b, need ack=00 and one gnt",
                     k, c, a, {gnt1, gnt0});
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_strobe();
    run_xacts(1, 0, 0, 0, 1'b1, 1'b0, 8'h00, 8'h00, "pre_read0");
    req0 = 1; rw0 = 1; addr0 = 1'b1; wdata0 = 8'h55;
    tick();
    tick();
    tests++;
    if (ram_we !== 1'b1) begin
      fails++;
      $display("FAIL midrst_strobe: we=%b, need 1", ram_we);
    end
    clear_n = 1'b0;
    req0 = 0;
    model_reset();
    #1;
    tests++;
    if ({gnt1, gnt0, ram_en, ram_we, ack1, ack0} !== 6'b0 || ram_addr !== '0 ||
        ram_wdata !== '0 || rdata0 !== '0) begin
      fails++;
      $display("FAIL midrst_async: ctl=%b addr=%h wdata=%h rd0=%h, need all 0",
               {gnt1, gnt0, ram_en, ram_we, ack1, ack0}, ram_addr, ram_wdata, rdata0);
    end
    @(negedge clk);
    clear_n = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      tests++;
      if ({ack1, ack0} !== 2'b00) begin
        fails++;
        $display("FAIL midrst_noack: ack=%b, need 00", {ack1, ack0});
      end
    end
    run_xacts(1, 0, 0, 0, 1'b1, 1'b0, 8'h00, 8'h00, "post_rst_read");
  endtask

  task automatic test_ignore_changes();
    int unsigned nack;
    req0 = 1; rw0 = 1; addr0 = 1'b0; wdata0 = 8'hA5;
    tick();  // SETUP
    req0 = 0; rw0 = 0; addr0 = 1'b1; wdata0 = 8'hFF;
    tick();  // STROBE
    tests++;
    if (ram_we !== 1'b1 || ram_addr !== 1'b0 || ram_wdata !== 8'hA5) begin
      fails++;
      $display("FAIL ignore_strobe: we=%b addr=%h wdata=%h, need we=1 addr=0 wdata=a5",
               ram_we, ram_addr, ram_wdata);
    end
    mem_m[0] = 8'hA5;
    last_m   = 1'b0;
    nack = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      tick();
      if (ack0) nack++;
    end
    tests++;
    if (nack != 1) begin
      fails++;
      $display("FAIL ignore_ackcount: acks=%0d, need 1", nack);
    end
    run_xacts(1, 0, 0, 0, 1'b0, 1'b0, 8'h00, 8'h00, "ignore_readback");
  endtask

  task automatic test_random();
    bit e0, e1;
    for (int unsigned i = 0; i < 25; i++) begin
      e0 = $urandom_range(0, 1);
      e1 = $urandom_range(0, 1);
      if (!e0 && !e1) e0 = 1'b1;
      run_xacts(e0, e1, $urandom_range(0, 1), $urandom_range(0, 1),
                AW'($urandom_range(0, 2**AW - 1)), AW'($urandom_range(0, 2**AW - 1)),
                DW'($urandom), DW'($urandom), "random");
    end
  endtask

  initial begin
    for (int unsigned i = 0; i < 2**AW; i++) begin
      ram_mem[i] = '0;
      mem_m[i]   = '0;
    end
    test_reset();
    test_write();
    test_read_back();
    test_contention();
    test_reset_mid_strobe();
    test_ignore_changes();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
